tone_noise_gen: RTL and testbench
=================================

# tone_noise_gen

Parametrised multi-channel audio tone and noise generator. It is the next generation of the single divider/noise peripheral pair exported from the Nios practice system. Software writes per-channel frequency divisors, and the block produces CHANNELS independent square waves, an LFSR noise source with step strobe, and a registered mix level. It sits between the Nios PIO/Avalon-export layer and the board's audio/LED outputs.

## Interface
Parameters:
- CHANNELS, 4, number of tone channels (1..8)
- DIV_W, 32, divisor width per channel
- NOISE_W, 16, LFSR width; legal values 8, 16, 24, 32
- MIX_W, $clog2(CHANNELS+2), width of mix_out (derived, not overridable)

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- wr_en  in  1  divisor write strobe, one cycle
- wr_addr  in  $clog2(CHANNELS+1)  0..CHANNELS-1 select a tone channel; CHANNELS selects the noise divisor
- wr_data  in  DIV_W  divisor value
- ch_en  in  CHANNELS  per-channel enable mask
- noise_en  in  1  noise generator enable
- tone_out  out  CHANNELS  square wave per channel
- noise_out  out  NOISE_W  LFSR state
- noise_pulse  out  1  single-cycle strobe on each LFSR step
- mix_out  out  MIX_W  registered count of high sources

## Operation
- Each channel has a divisor register div[i], a counter cnt[i] and a square-wave bit sq[i].
- Channel active when ch_en[i]=1 and div[i]≠0. When inactive, cnt=0 and sq=0.
- Active channel: cnt increments each cycle. When cnt==div-1, sq toggles and cnt returns to 0. Output frequency = f_clk/(2·div). div=1 toggles every cycle.
- Write to channel i: div[i]←wr_data, cnt[i]←0, sq[i]←0 on the same edge. The new period starts the following cycle.
- Writes to wr_addr>CHANNELS are ignored.
- Noise divisor ndiv and counter ncnt follow the same rule, enabled by noise_en and ndiv≠0.
- At each terminal count the LFSR takes one Galois step (shift right, XOR taps when LSB=1) and noise_pulse=1 for that cycle.
- Taps: 8→0xB8, 16→0xB400, 24→0xE10000, 32→0xA3000000.
- The LFSR holds its value while disabled and does not reseed.
- If the LFSR state is ever 0, it is forced to 1 on the next edge (lock-up guard).
- mix_out = popcount(tone_out) + noise_out[0]·noise_en, registered.

## Timing
- Reset values: all div/ndiv=0, cnt/ncnt=0, tone_out=0, noise_out=1, noise_pulse=0, mix_out=0.
- Reset dominates a simultaneous wr_en.
- tone_out and noise_pulse are registered: a toggle appears the cycle after cnt==div-1 is sampled.
- mix_out lags tone_out/noise_out by exactly 1 cycle.
- ch_en falling: sq and cnt are cleared on the next edge. ch_en rising: counting starts from cnt=0 and sq=0.
- Write and terminal count on the same cycle: the write wins and no toggle occurs.
- Counters never exceed div-1. Lowering div below the current cnt is impossible because every write clears cnt.

## Configuration
- TONE_NOISE_GEN_NOISE_EN defined: LFSR, noise divisor, noise_pulse and the noise term in mix_out are present.
- Not defined: noise logic is not compiled. noise_out ties to 0 and noise_pulse to 0. Writes to wr_addr==CHANNELS are ignored. MIX_W is unchanged.

## Structure
- Package tone_noise_pkg holds:
  - the LFSR tap constants per NOISE_W
  - a function lfsr_taps(width)
  - a function popcount
  - the legal NOISE_W check
- Sub-module tone_div_ch: one divisor/counter/square channel (inputs load, load_val, en; outputs sq, tick).
  - Instantiated CHANNELS times.
  - Reused for the noise divisor, using its tick to step the LFSR.

## Test plan
- Reset, then write div[0]=3 with ch_en=4'b0001: tone_out[0] toggles every 3 cycles (period 6). Other outputs stay 0. mix_out alternates 0/1 one cycle after tone_out.
- Write div[1]=0 with ch_en[1]=1: tone_out[1] stays 0 indefinitely.
- Write div[2]=5 mid-period while running at 2: the next toggle occurs 5 cycles after the write, with sq restarted from 0.
- Noise, NOISE_W=16, ndiv=1, noise_en=1: from seed 0x0001, noise_out steps to 0xB400, then 0x5A00. noise_pulse is high every cycle. After 65535 steps the state returns to 0x0001.
- All 4 channels with div=1 and noise enabled: mix_out reaches 5 (3'b101) without overflow. Assert reset mid-run: all outputs return to their reset values on the next edge.
- Build without TONE_NOISE_GEN_NOISE_EN: a write to wr_addr=4 has no effect, and noise_out=0 and noise_pulse=0 throughout.

Source files
------------

// File: rtl/tone_noise_gen_pkg.sv
// Shared constants and helpers for the tone/noise generator: LFSR taps per
// width, the legal-width check and a small popcount used by the mix stage.
package tone_noise_pkg;

    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_32 = 32'hA300_0000;

    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] t;
        t = '0;
        case (width)
            8:       t = TAPS_8;
            16:      t = TAPS_16;
            24:      t = TAPS_24;
            32:      t = TAPS_32;
            default: t = '0;
        endcase
        return t;
    endfunction

    function automatic bit noise_w_legal(input int width);
        return (width == 8) || (width == 16) || (width == 24) || (width == 32);
    endfunction

    // Up to eight tone channels feed the mix, so an 8-bit input covers every build.
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tone_noise_gen_div_ch.sv
// One divisor channel: holds div, counts to div-1 and toggles a registered
// square bit. tick flags the terminal-count cycle combinationally.
module tone_div_ch
    import tone_noise_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             sq,
    output logic             tick
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic             active;
    logic             at_end;

    // A load on the terminal cycle wins, so tick is suppressed with it.
    always_comb begin
        active = en && (div != '0);
        at_end = active && (cnt == div - DIV_W'(1));
        tick   = at_end && !load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            cnt <= '0;
            sq  <= 1'b0;
        end else if (load) begin
            div <= load_val;
            cnt <= '0;
            sq  <= 1'b0;
        end else if (!active) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (at_end) begin
            cnt <= '0;
            sq  <= ~sq;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/tone_noise_gen.sv
// Multi-channel square-wave tone generator with optional Galois LFSR noise
// source (macro TONE_NOISE_GEN_NOISE_EN) and a registered count of high sources.
module tone_noise_gen
    import tone_noise_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 32,
    parameter int NOISE_W  = 16
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset,
    input  logic                            wr_en,
    input  logic [$clog2(CHANNELS+1)-1:0]   wr_addr,
    input  logic [DIV_W-1:0]                wr_data,
    input  logic [CHANNELS-1:0]             ch_en,
    input  logic                            noise_en,
    output logic [CHANNELS-1:0]             tone_out,
    output logic [NOISE_W-1:0]              noise_out,
    output logic                            noise_pulse,
    output logic [$clog2(CHANNELS+2)-1:0]   mix_out
);

    localparam int AW    = $clog2(CHANNELS+1);
    localparam int MIX_W = $clog2(CHANNELS+2);

    if (!noise_w_legal(NOISE_W) || CHANNELS < 1 || CHANNELS > 8) begin : g_bad_params
        $error("tone_noise_gen: NOISE_W must be 8/16/24/32 and CHANNELS 1..8");
    end

    // wr_en is a single-cycle strobe with no back-pressure: the addressed
    // divisor is loaded on that edge; addresses above CHANNELS match nothing.
    logic [CHANNELS-1:0] tone_tick_unused;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        tone_div_ch #(.DIV_W(DIV_W)) u_ch (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .load     (wr_en && (wr_addr == AW'(g))),
            .load_val (wr_data),
            .en       (ch_en[g]),
            .sq       (tone_out[g]),
            .tick     (tone_tick_unused[g])
        );
    end

`ifdef TONE_NOISE_GEN_NOISE_EN
    localparam logic [NOISE_W-1:0] NOISE_TAPS = NOISE_W'(lfsr_taps(NOISE_W));

    logic               noise_tick;
    logic               noise_sq_unused;
    logic [NOISE_W-1:0] lfsr;

    tone_div_ch #(.DIV_W(DIV_W)) u_noise_div (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .load     (wr_en && (wr_addr == AW'(CHANNELS))),
        .load_val (wr_data),
        .en       (noise_en),
        .sq       (noise_sq_unused),
        .tick     (noise_tick)
    );

    // The all-zero guard takes priority so a corrupted state recovers in one edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            lfsr        <= NOISE_W'(1);
            noise_pulse <= 1'b0;
        end else begin
            noise_pulse <= noise_tick;
            if (lfsr == '0) begin
                lfsr <= NOISE_W'(1);
            end else if (noise_tick) begin
                lfsr <= (lfsr >> 1) ^ (lfsr[0] ? NOISE_TAPS : '0);
            end
        end
    end

    assign noise_out = lfsr;
`else
    assign noise_out   = '0;
    assign noise_pulse = 1'b0;
`endif

    logic [3:0] mix_next;

    always_comb begin
        mix_next = popcount(8'(tone_out)) + {3'b000, noise_out[0] & noise_en};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mix_out <= '0;
        end else begin
            mix_out <= mix_next[MIX_W-1:0];
        end
    end

endmodule

// File: tb/tb_tone_noise_gen.sv
// Directed bench for tone_noise_gen: a driver issues stimulus and queues the
// expected outputs for each edge; a monitor pops and compares mid-cycle.
module tb_tone_noise_gen;

`ifdef TONE_NOISE_GEN_NOISE_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif
    localparam int W = 4 + 16 + 1 + 3;

    logic        clk = 1'b0;
    logic        reset_reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  ch_en;
    logic        noise_en;
    logic [3:0]  tone_out;
    logic [15:0] noise_out;
    logic        noise_pulse;
    logic [2:0]  mix_out;

    tone_noise_gen dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ch_en       (ch_en),
        .noise_en    (noise_en),
        .tone_out    (tone_out),
        .noise_out   (noise_out),
        .noise_pulse (noise_pulse),
        .mix_out     (mix_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;
    string        cur_name;
    bit           track_mix = 1'b0;
    int           max_mix   = 0;

    // expectation model: closed-form phase from the last load/idle edge
    longint       k = 0;
    int unsigned  m_div[4];
    longint       m_base[4];
    int unsigned  m_ndiv = 0;
    longint       m_nbase = 0;
    logic [15:0]  m_lfsr = 16'h0000;
    logic [3:0]   m_tone = 4'h0;

    task automatic cyc(input string nm);
        logic [3:0] t;
        logic       p;
        logic [2:0] mx;
        k++;
        mx = reset_reset ? 3'd0 : 3'($countones(m_tone)) + {2'b00, m_lfsr[0] & noise_en};
        for (int i = 0; i < 4; i++) begin
            if (reset_reset) begin
                m_div[i] = 0; m_base[i] = k; t[i] = 1'b0;
            end else if (wr_en && wr_addr == 3'(i)) begin
                m_div[i] = wr_data; m_base[i] = k; t[i] = 1'b0;
            end else if (!ch_en[i] || m_div[i] == 0) begin
                m_base[i] = k; t[i] = 1'b0;
            end else begin
                t[i] = (((k - m_base[i]) / longint'(m_div[i])) % 2) != 0;
            end
        end
        p = 1'b0;
        if (reset_reset) begin
            m_ndiv = 0; m_nbase = k; m_lfsr = NOISE_ON ? 16'h0001 : 16'h0000;
        end else if (NOISE_ON) begin
            if (wr_en && wr_addr == 3'd4) begin
                m_ndiv = wr_data; m_nbase = k;
            end else if (!noise_en || m_ndiv == 0) begin
                m_nbase = k;
            end else if (((k - m_nbase) % longint'(m_ndiv)) == 0) begin
                p = 1'b1;
                m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            end
        end
        m_tone = t;
        @(posedge clk);
        #1;
        exp_q.push_back({t, m_lfsr, p, mx});
        name_q.push_back(nm);
    endtask

    task automatic write_div(input logic [2:0] a, input logic [31:0] d, input string nm);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc(nm);
        wr_en = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_w    = exp_q.pop_front();
            cur_name = name_q.pop_front();
            act_w    = {tone_out, noise_out, noise_pulse, mix_out};
            checks++;
            if (act_w !== exp_w) begin
                failures++;
                $display("FAIL %s @edge: tone=%b noise=%h pulse=%b mix=%0d, required tone=%b noise=%h pulse=%b mix=%0d",
                         cur_name, act_w[23:20], act_w[19:4], act_w[3], act_w[2:0],
                         exp_w[23:20], exp_w[19:4], exp_w[3], exp_w[2:0]);
            end
        end
        if (track_mix && int'(mix_out) > max_mix) max_mix = int'(mix_out);
    end

    // driver
    initial begin
        reset_reset = 1'b1; ch_en = 4'b0000; noise_en = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd7;
        cyc("reset_with_write");
        cyc("reset_hold");
        reset_reset = 1'b0; wr_en = 1'b0; ch_en = 4'b0001;
        repeat (4) cyc("idle_div0_zero");

        write_div(3'd0, 32'd3, "wr_div0_3");
        repeat (14) cyc("ch0_div3");

        ch_en = 4'b0011;
        write_div(3'd1, 32'd0, "wr_div1_0");
        repeat (8) cyc("ch1_div0");

        ch_en = 4'b0111;
        write_div(3'd2, 32'd2, "wr_div2_2");
        repeat (7) cyc("ch2_div2");
        write_div(3'd2, 32'd5, "wr_div2_5");
        repeat (12) cyc("ch2_div5");

        write_div(3'd5, 32'd1, "wr_addr_5_ignored");
        repeat (4) cyc("after_bad_addr");

        ch_en = 4'b0110;
        repeat (4) cyc("ch0_off");
        ch_en = 4'b0111;
        repeat (8) cyc("ch0_on");

        write_div(3'd0, 32'd3, "wr_div0_3_again");
        cyc("ch0_count1");
        cyc("ch0_count2");
        write_div(3'd0, 32'd3, "wr_on_terminal");
        chk("wr_on_terminal_tone0", 32'(tone_out[0]), 32'd0);
        repeat (6) cyc("after_collision");

        reset_reset = 1'b1;
        cyc("reset_before_noise");
        reset_reset = 1'b0; ch_en = 4'b0000; noise_en = 1'b1;
        write_div(3'd4, 32'd1, "wr_ndiv_1");
        cyc("noise_step1");
        chk("noise_step1_value", 32'(noise_out), NOISE_ON ? 32'hB400 : 32'h0);
        chk("noise_step1_pulse", 32'(noise_pulse), NOISE_ON ? 32'd1 : 32'd0);
        cyc("noise_step2");
        chk("noise_step2_value", 32'(noise_out), NOISE_ON ? 32'h5A00 : 32'h0);
        repeat (65533) cyc("noise_run");
        chk("noise_full_period", 32'(noise_out), NOISE_ON ? 32'h0001 : 32'h0);

        for (int i = 0; i < 4; i++) write_div(3'(i), 32'd1, "wr_div_1_all");
        ch_en = 4'b1111;
        track_mix = 1'b1;
        repeat (40) cyc("mix_all");
        track_mix = 1'b0;
        chk("mix_max", 32'(max_mix), NOISE_ON ? 32'd5 : 32'd4);

        reset_reset = 1'b1;
        cyc("reset_mid_run");
        reset_reset = 1'b0;
        repeat (3) cyc("after_mid_reset");

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
